// File: rtl/alu_res_queue.sv
// Result queue behind an add/sub stage: tracks in-flight issues, saturates results, buffers them FIFO.
// Optional saturation-event counter enabled by defining ALU_RES_OVF_CNT_EN.
module alu_res_queue #(
    parameter int IN_WL    = 16,
    parameter int OUT_WL   = 15,
    parameter int DEPTH    = 4,
    parameter int PIPE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ok,
    input  logic [IN_WL-1:0]  r,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_WL-1:0] out_data,
    output logic              out_ovf,
    output logic              err,
    output logic [7:0]        ovf_cnt
);

    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = AW + 1;
    localparam int unsigned DEPTH_U = DEPTH;

    logic [PIPE_LAT-1:0] vsr;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic [OUT_WL-1:0]   mem_data [DEPTH];
    logic                mem_ovf  [DEPTH];

    logic                arrive, full, pop, push_acc;
    logic                in_range;
    logic [OUT_WL-1:0]   sat_data;
    logic                sat_ovf;
    int unsigned         inflight;

    assign arrive    = vsr[PIPE_LAT-1];
    assign full      = (count == CW'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A full queue only accepts the arriving result when the head leaves in the same cycle.
    assign push_acc  = arrive && (!full || pop);

    always_comb begin
        inflight = 0;
        for (int unsigned i = 0; i < PIPE_LAT; i++) begin
            inflight = inflight + 32'(vsr[i]);
        end
    end

    assign issue_ok = (32'(count) + inflight) < DEPTH_U;

    assign in_range = (&r[IN_WL-1:OUT_WL-1]) || !(|r[IN_WL-1:OUT_WL-1]);

    always_comb begin
        sat_data = r[OUT_WL-1:0];
        sat_ovf  = 1'b0;
        if (!in_range) begin
            sat_ovf  = 1'b1;
            sat_data = r[IN_WL-1] ? {1'b1, {(OUT_WL-1){1'b0}}}
                                  : {1'b0, {(OUT_WL-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsr <= '0;
        end else begin
            vsr[0] <= issue_valid;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                vsr[i] <= vsr[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            case ({push_acc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (arrive && full && !pop) err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_data[wr_ptr] <= sat_data;
            mem_ovf[wr_ptr]  <= sat_ovf;
        end
    end

    assign out_data = out_valid ? mem_data[rd_ptr] : '0;
    assign out_ovf  = out_valid ? mem_ovf[rd_ptr]  : 1'b0;

`ifdef ALU_RES_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (push_acc && sat_ovf && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end
`else
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_res_queue.sv
// Directed self-checking bench for alu_res_queue at default parameters.
module tb_alu_res_queue;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_ok;
    logic [15:0] r;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_data;
    logic        out_ovf;
    logic        err;
    logic [7:0]  ovf_cnt;

    int checks   = 0;
    int failures = 0;

    alu_res_queue #(.IN_WL(16), .OUT_WL(15), .DEPTH(4), .PIPE_LAT(1)) dut (
        .clk(clk),
        .rst(rst),
        .issue_valid(issue_valid),
        .issue_ok(issue_ok),
        .r(r),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_ovf(out_ovf),
        .err(err),
        .ovf_cnt(ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, present r on the arrive cycle, check the queued head, then pop it.
    task automatic one(input string tag, input logic [15:0] rv, input logic [14:0] ed, input logic eo);
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        r = rv;
        chk({tag, "_nobypass"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(ed));
        chk({tag, "_ovf"}, 32'(out_ovf), 32'(eo));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] exp_q [4];
        logic [7:0]  exp_cnt;

        rst = 1'b1; issue_valid = 1'b0; r = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ovf", 32'(out_ovf), 32'd0);
        chk("rst_ok", 32'(issue_ok), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cnt", 32'(ovf_cnt), 32'd0);

        one("lat5", 16'h0005, 15'h0005, 1'b0);
        one("pos_sat", 16'h4000, 15'h3FFF, 1'b1);
        one("neg_sat", 16'hBFFF, 15'h4000, 1'b1);
        one("neg_edge", 16'hC000, 15'h4000, 1'b0);
        one("pos_edge", 16'h3FFF, 15'h3FFF, 1'b0);
        one("min_sat", 16'h8000, 15'h4000, 1'b1);
        one("minus1", 16'hFFFF, 15'h7FFF, 1'b0);

        // Well-behaved upstream fills the queue; arrivals carry 101..104.
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("fill_ok%0d", c), 32'(issue_ok), (c < 4) ? 32'd1 : 32'd0);
            issue_valid = issue_ok;
            r = 16'(100 + c);
            tick();
        end
        issue_valid = 1'b0;
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_head", 32'(out_data), 32'd101);
        chk("full_ok", 32'(issue_ok), 32'd0);
        chk("full_err", 32'(err), 32'd0);

        // Overrun: forced issue while full and stalled is dropped.
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        r = 16'h0777;
        tick();
        chk("ovr_err", 32'(err), 32'd1);
        chk("ovr_hold", 32'(out_data), 32'd101);
        chk("ovr_ok", 32'(issue_ok), 32'd0);

        // Push and pop together while full keeps occupancy at 4.
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        r = 16'h0222;
        out_ready = 1'b1;
        chk("pp_head", 32'(out_data), 32'd101);
        tick();
        out_ready = 1'b0;
        chk("pp_head2", 32'(out_data), 32'd102);
        chk("pp_ok", 32'(issue_ok), 32'd0);
        chk("pp_err", 32'(err), 32'd1);

        exp_q[0] = 16'd102; exp_q[1] = 16'd103; exp_q[2] = 16'd104; exp_q[3] = 16'h0222;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_v%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("drain_d%0d", k), 32'(out_data), 32'(exp_q[k]));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("drain_ok", 32'(issue_ok), 32'd1);

        // Reset with two entries queued and one issue in flight.
        issue_valid = 1'b1;
        tick();
        r = 16'h0011;
        tick();
        r = 16'h0012;
        tick();
        rst = 1'b1;
        r = 16'h0013;
        tick();
        rst = 1'b0;
        issue_valid = 1'b0;
        r = 16'h0055;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("mid_rst_v%0d", k), 32'(out_valid), 32'd0);
            chk($sformatf("mid_rst_d%0d", k), 32'(out_data), 32'd0);
            tick();
        end
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_ok", 32'(issue_ok), 32'd1);
        chk("mid_rst_cnt", 32'(ovf_cnt), 32'd0);

        // 300 saturating pushes with the consumer always ready.
        out_ready = 1'b1;
        r = 16'h7FFF;
        for (int k = 0; k < 300; k++) begin
            issue_valid = 1'b1;
            tick();
        end
        issue_valid = 1'b0;
        tick(); tick();
`ifdef ALU_RES_OVF_CNT_EN
        exp_cnt = 8'd255;
`else
        exp_cnt = 8'd0;
`endif
        chk("ovf_cnt300", 32'(ovf_cnt), 32'(exp_cnt));
        chk("ovf_err", 32'(err), 32'd0);
        chk("ovf_empty", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
